// File: rtl/stage_fetch_if.sv
// -----------------------------------------------------------------------------
// stage_fetch_if
// Instruction-memory bus between the fetch stage and instruction memory.
//
// Signals
//   ihit      memory -> fetch  imemload holds a valid word this cycle
//   imemload  memory -> fetch  instruction word (32 bits)
//   iREN      fetch -> memory  instruction read request
//   imemaddr  fetch -> memory  fetch address (current PC)
//
// Handshake: fetch holds iREN and imemaddr steady while it waits. A word is
// consumed only in a cycle where iREN=1 and ihit=1. The fetch stage must also
// be free to accept it in that cycle, or have buffer space for it. Otherwise
// the word is dropped and fetched again from the same address.
//
// Modports
//   master  fetch-stage view
//   slave   instruction-memory view
// -----------------------------------------------------------------------------
interface stage_fetch_if;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] imemaddr;

    modport master (input ihit, input imemload, output iREN, output imemaddr);
    modport slave  (output ihit, output imemload, input iREN, input imemaddr);
endinterface

// File: rtl/stage_fetch.sv
// -----------------------------------------------------------------------------
// stage_fetch
// Instruction fetch stage: owns the PC, issues instruction reads, applies
// branch/jump redirects resolved in EX and stops permanently on halt.
//
// Optional feature (macro STAGE_FETCH_IBUF_EN): a one-entry skid buffer.
// It keeps a word that arrives while IF/ID is stalled instead of refetching it.
//
// Ports
//   CLK            clock, rising edge
//   nRST           synchronous active-low reset
//   imem           stage_fetch_if.master (ihit, imemload, iREN, imemaddr)
//   stall_in       hazard stall, IF/ID holds
//   halt_in        halt retiring from MEM
//   branchSel_in   EX branch taken
//   branchaddr_in  branch target
//   jump_in        0 none, 1 j/jal, 2 jr, 3 none
//   jumpaddr_in    j/jal target
//   jraddr_in      jr target
//   instr_out      instruction to IF/ID
//   npc_out        delivered instruction address + 4
//   valid_out      instr_out/npc_out valid for capture
//   flush_out      squash IF/ID and ID/EX
//   dbg_state      {buffer full, halted}
// -----------------------------------------------------------------------------
module stage_fetch #(
    parameter logic [31:0] PC_INIT = 32'h00000000
) (
    input  logic          CLK,
    input  logic          nRST,
    stage_fetch_if.master imem,
    input  logic          stall_in,
    input  logic          halt_in,
    input  logic          branchSel_in,
    input  logic [31:0]   branchaddr_in,
    input  logic [1:0]    jump_in,
    input  logic [31:0]   jumpaddr_in,
    input  logic [31:0]   jraddr_in,
    output logic [31:0]   instr_out,
    output logic [31:0]   npc_out,
    output logic          valid_out,
    output logic          flush_out,
    output logic [1:0]    dbg_state
);

    typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

    state_t      state, state_next;
    logic [31:0] pc, pc_next, pc_plus4;
    logic        redirect_req;
    logic [31:0] redirect_target;
    logic        buf_full_q;

`ifdef STAGE_FETCH_IBUF_EN
    logic        buf_full, buf_full_next, buf_load;
    logic [31:0] buf_instr, buf_npc;
    assign buf_full_q = buf_full;
`else
    assign buf_full_q = 1'b0;
`endif

    assign pc_plus4      = pc + 32'd4;   // wraps modulo 2^32
    assign imem.imemaddr = pc;
    assign dbg_state     = {buf_full_q, state};

    // jump_in=3 is treated as no jump; jr beats j, and j beats branch.
    always_comb begin
        redirect_req    = branchSel_in || (jump_in == 2'd1) || (jump_in == 2'd2);
        redirect_target = branchaddr_in;
        if (jump_in == 2'd2)
            redirect_target = jraddr_in;
        else if (jump_in == 2'd1)
            redirect_target = jumpaddr_in;
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        imem.iREN  = (state == S_RUN) && !buf_full_q;
        valid_out  = 1'b0;
        flush_out  = 1'b0;
        instr_out  = imem.imemload;
        npc_out    = pc_plus4;
`ifdef STAGE_FETCH_IBUF_EN
        buf_full_next = buf_full;
        buf_load      = 1'b0;
`endif
        case (state)
            S_RUN: begin
                if (halt_in) begin
                    // Halt wins over a same-cycle redirect: PC freezes here.
                    state_next = S_HALT;
                end else if (redirect_req) begin
                    flush_out = 1'b1;
                    pc_next   = redirect_target;
`ifdef STAGE_FETCH_IBUF_EN
                    buf_full_next = 1'b0;
`endif
                end else begin
`ifdef STAGE_FETCH_IBUF_EN
                    if (buf_full) begin
                        if (!stall_in) begin
                            valid_out     = 1'b1;
                            instr_out     = buf_instr;
                            npc_out       = buf_npc;
                            buf_full_next = 1'b0;
                        end
                    end else if (imem.ihit) begin
                        pc_next = pc_plus4;
                        if (stall_in) begin
                            buf_load      = 1'b1;
                            buf_full_next = 1'b1;
                        end else begin
                            valid_out = 1'b1;
                        end
                    end
`else
                    // A word that arrives during a stall is dropped and refetched.
                    if (imem.ihit && !stall_in) begin
                        valid_out = 1'b1;
                        pc_next   = pc_plus4;
                    end
`endif
                end
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: state_next = S_RUN;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= S_RUN;
            pc    <= PC_INIT;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

`ifdef STAGE_FETCH_IBUF_EN
    always_ff @(posedge CLK) begin
        if (!nRST)
            buf_full <= 1'b0;
        else
            buf_full <= buf_full_next;
    end

    // Payload needs no reset; it is only read while buf_full is set.
    always_ff @(posedge CLK) begin
        if (buf_load) begin
            buf_instr <= imem.imemload;
            buf_npc   <= pc_plus4;
        end
    end
`endif

endmodule

// File: tb/tb_stage_fetch.sv
// -----------------------------------------------------------------------------
// tb_stage_fetch
// Directed bench for stage_fetch. Inputs change 1 ns after the rising edge.
// Outputs are sampled in mid-cycle.
// -----------------------------------------------------------------------------
module tb_stage_fetch;

    logic        clk;
    logic        nrst;
    logic        stall_in, halt_in, branch_sel;
    logic [31:0] branch_addr, jump_addr, jr_addr;
    logic [1:0]  jump_in;
    logic [31:0] instr_out, npc_out;
    logic        valid_out, flush_out;
    logic [1:0]  dbg_state;

    int vectors     = 0;
    int miscompares = 0;

    stage_fetch_if imem_bus ();

    stage_fetch dut (
        .CLK           (clk),
        .nRST          (nrst),
        .imem          (imem_bus),
        .stall_in      (stall_in),
        .halt_in       (halt_in),
        .branchSel_in  (branch_sel),
        .branchaddr_in (branch_addr),
        .jump_in       (jump_in),
        .jumpaddr_in   (jump_addr),
        .jraddr_in     (jr_addr),
        .instr_out     (instr_out),
        .npc_out       (npc_out),
        .valid_out     (valid_out),
        .flush_out     (flush_out),
        .dbg_state     (dbg_state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_redirect();
        branch_sel = 1'b0;
        jump_in    = 2'd0;
    endtask

    initial begin
        nrst = 1'b0; stall_in = 1'b0; halt_in = 1'b0;
        branch_sel = 1'b0; jump_in = 2'd0;
        branch_addr = '0; jump_addr = '0; jr_addr = '0;
        imem_bus.ihit = 1'b0; imem_bus.imemload = '0;

        // reset state
        step();
        chk("rst_addr",  imem_bus.imemaddr, 32'h0);
        chk("rst_iren",  imem_bus.iREN, 32'h1);
        chk("rst_valid", valid_out, 32'h0);
        chk("rst_flush", flush_out, 32'h0);

        // sequential fetch 0,4,8
        nrst = 1'b1; imem_bus.ihit = 1'b1; imem_bus.imemload = 32'hA000_0000;
        settle();
        chk("seq0_addr",  imem_bus.imemaddr, 32'h0);
        chk("seq0_npc",   npc_out, 32'h4);
        chk("seq0_valid", valid_out, 32'h1);
        chk("seq0_instr", instr_out, 32'hA000_0000);
        step(); imem_bus.imemload = 32'hA000_0001; settle();
        chk("seq1_addr",  imem_bus.imemaddr, 32'h4);
        chk("seq1_npc",   npc_out, 32'h8);
        chk("seq1_valid", valid_out, 32'h1);
        step(); imem_bus.imemload = 32'hA000_0002; settle();
        chk("seq2_addr",  imem_bus.imemaddr, 32'h8);
        chk("seq2_npc",   npc_out, 32'hC);
        chk("seq2_valid", valid_out, 32'h1);
        step();
        chk("seq3_addr",  imem_bus.imemaddr, 32'hC);

        // j to 0x40, then branch to 0x100
        jump_in = 2'd1; jump_addr = 32'h40; settle();
        chk("j_flush", flush_out, 32'h1);
        chk("j_valid", valid_out, 32'h0);
        step(); clear_redirect();
        chk("j_addr", imem_bus.imemaddr, 32'h40);
        branch_sel = 1'b1; branch_addr = 32'h100; settle();
        chk("br_flush", flush_out, 32'h1);
        chk("br_valid", valid_out, 32'h0);
        step(); clear_redirect(); settle();
        chk("br_addr",    imem_bus.imemaddr, 32'h100);
        chk("br_noflush", flush_out, 32'h0);

        // priority: jr > j > branch
        jump_in = 2'd2; jr_addr = 32'h200; jump_addr = 32'h400;
        branch_sel = 1'b1; branch_addr = 32'h300;
        step();
        chk("jr_prio_addr", imem_bus.imemaddr, 32'h200);
        jump_in = 2'd1; jump_addr = 32'h20;
        step(); clear_redirect();
        chk("j_prio_addr", imem_bus.imemaddr, 32'h20);

        // jump_in=3 is no redirect; ihit=0 holds PC
        jump_in = 2'd3; imem_bus.ihit = 1'b0; settle();
        chk("j3_flush", flush_out, 32'h0);
        chk("nohit_valid", valid_out, 32'h0);
        step(); jump_in = 2'd0;
        chk("nohit_addr", imem_bus.imemaddr, 32'h20);

        // stall with ihit at 0x20
        imem_bus.ihit = 1'b1; stall_in = 1'b1; imem_bus.imemload = 32'hC000_0000; settle();
        chk("stall_valid", valid_out, 32'h0);
        chk("stall_flush", flush_out, 32'h0);
        step();
        imem_bus.imemload = 32'hC000_0001; stall_in = 1'b0;
`ifdef STAGE_FETCH_IBUF_EN
        chk("stall_addr", imem_bus.imemaddr, 32'h24);
        chk("buf_iren",   imem_bus.iREN, 32'h0);
        settle();
        chk("buf_valid", valid_out, 32'h1);
        chk("buf_npc",   npc_out, 32'h24);
        chk("buf_instr", instr_out, 32'hC000_0000);
`else
        chk("stall_addr", imem_bus.imemaddr, 32'h20);
        settle();
        chk("unstall_valid", valid_out, 32'h1);
        chk("unstall_npc",   npc_out, 32'h24);
        chk("unstall_instr", instr_out, 32'hC000_0001);
`endif
        step();
        chk("post_stall_addr", imem_bus.imemaddr, 32'h24);

        // wrap at top of address space
        imem_bus.ihit = 1'b0; jump_in = 2'd2; jr_addr = 32'hFFFF_FFFC;
        step(); jump_in = 2'd0; imem_bus.ihit = 1'b1; settle();
        chk("wrap_pc",    imem_bus.imemaddr, 32'hFFFF_FFFC);
        chk("wrap_npc",   npc_out, 32'h0);
        chk("wrap_valid", valid_out, 32'h1);
        step();
        chk("wrap_addr", imem_bus.imemaddr, 32'h0);

        // halt at 0x10, redirect in the same cycle is ignored
        imem_bus.ihit = 1'b0; jump_in = 2'd1; jump_addr = 32'h10;
        step(); jump_in = 2'd0;
        halt_in = 1'b1; branch_sel = 1'b1; branch_addr = 32'h80; imem_bus.ihit = 1'b1; settle();
        chk("halt_in_flush", flush_out, 32'h0);
        chk("halt_in_valid", valid_out, 32'h0);
        step(); halt_in = 1'b0;
        chk("halt_addr",  imem_bus.imemaddr, 32'h10);
        chk("halt_iren",  imem_bus.iREN, 32'h0);
        chk("halt_state", dbg_state, 32'h1);
        settle();
        chk("halted_flush", flush_out, 32'h0);
        chk("halted_valid", valid_out, 32'h0);
        step();
        chk("halted_addr", imem_bus.imemaddr, 32'h10);
        chk("halted_iren", imem_bus.iREN, 32'h0);
        clear_redirect();

        // reset releases halt
        nrst = 1'b0; step();
        chk("unhalt_addr",  imem_bus.imemaddr, 32'h0);
        chk("unhalt_iren",  imem_bus.iREN, 32'h1);
        chk("unhalt_state", dbg_state, 32'h0);

        // reset during a pending redirect discards it
        branch_sel = 1'b1; branch_addr = 32'h500; settle();
        chk("rst_redir_flush", flush_out, 32'h1);
        step(); clear_redirect();
        chk("rst_redir_addr", imem_bus.imemaddr, 32'h0);
        nrst = 1'b1; settle();
        chk("after_rst_valid", valid_out, 32'h1);
        chk("after_rst_npc",   npc_out, 32'h4);
        step();
        chk("after_rst_addr", imem_bus.imemaddr, 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stage_fetch.md
STAGE_FETCH -- requirements
Module: stage_fetch

Interface
REQ-001 SHALL have parameter PC_INIT, default 32'h00000000, PC value loaded at reset.
REQ-002 SHALL have port CLK  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port nRST  input  1  synchronous active-low reset, sampled only on rising CLK.
REQ-004 SHALL have port ihit  input  1  instruction memory returns valid imemload this cycle.
REQ-005 SHALL have port imemload  input  32  instruction word from instruction memory.
REQ-006 SHALL have port iREN  output  1  instruction read request.
REQ-007 SHALL have port imemaddr  output  32  fetch address, equal to current PC.
REQ-008 SHALL have port stall_in  input  1  hazard-unit stall; IF/ID holds its contents.
REQ-009 SHALL have port halt_in  input  1  halt retiring from MEM; stop fetch permanently.
REQ-010 SHALL have port branchSel_in  input  1  EX branch resolved taken.
REQ-011 SHALL have port branchaddr_in  input  32  EX branch target (npc + imm<<2).
REQ-012 SHALL have port jump_in  input  2  EX jump type: 0 none, 1 j/jal, 2 jr, 3 treated as 0.
REQ-013 SHALL have port jumpaddr_in  input  32  EX j/jal target ({npc[31:28], imm26<<2}).
REQ-014 SHALL have port jraddr_in  input  32  EX jr target (forwarded rs value).
REQ-015 SHALL have port instr_out  output  32  instruction to IF/ID latch.
REQ-016 SHALL have port npc_out  output  32  address of delivered instruction + 4.
REQ-017 SHALL have port valid_out  output  1  instr_out/npc_out valid for IF/ID capture.
REQ-018 SHALL have port flush_out  output  1  squash IF/ID and ID/EX this cycle.

Function
REQ-019 Redirect SHALL be active when jump_in is 1 or 2, or branchSel_in=1; target priority jr(2) > j(1) > branch.
REQ-020 On active redirect (and not halted): flush_out=1 combinationally, valid_out=0, PC <= target at next edge, regardless of ihit and stall_in.
REQ-021 Without redirect, ihit=1, stall_in=0, buffer empty: valid_out=1, instr_out=imemload, npc_out=PC+4, PC <= PC+4.
REQ-022 ihit=0 with no redirect: PC held, valid_out=0.
REQ-023 PC arithmetic SHALL be 32-bit modulo 2^32; 32'hFFFFFFFC + 4 wraps to 0.
REQ-024 iREN SHALL be 1 unless halted or (with buffer enabled) buffer full.
REQ-025 halt_in=1 SHALL set sticky halted flag at next edge; halted: iREN=0, valid_out=0, flush_out=0, PC frozen; halt_in same cycle as redirect: redirect ignored, PC frozen.
REQ-026 flush_out SHALL be 0 whenever no redirect is active.

Reset
REQ-027 nRST=0 at rising edge SHALL set PC=PC_INIT, halted=0, buffer empty; reset during pending redirect or full buffer discards them.
REQ-028 Outputs during and after reset: iREN=1, imemaddr=PC_INIT, valid_out=0 unless ihit, flush_out=0 unless redirect inputs active.

Configuration
REQ-029 Macro STAGE_FETCH_IBUF_EN SHALL compile in a one-entry instruction skid buffer.
REQ-030 With macro: ihit=1 and stall_in=1 and buffer empty -> capture {imemload, PC+4}, PC <= PC+4, buffer full; valid_out=0.
REQ-031 With macro: buffer full and stall_in=0 -> valid_out=1 from buffer contents, buffer empties at edge; no fetch (iREN=0) that cycle.
REQ-032 With macro: redirect clears the buffer at the edge; buffer full with stall_in=1 holds contents.
REQ-033 Without macro: ihit=1 and stall_in=1 -> PC held, valid_out=0, word discarded (refetched later).

Verification
REQ-034 Reset, then ihit=1 for 3 cycles, stall_in=0 -> imemaddr 0,4,8; npc_out 4,8,12; valid_out=1 each.
REQ-035 PC=0x40, branchSel_in=1, branchaddr_in=0x100, ihit=1 -> flush_out=1, valid_out=0, next imemaddr=0x100.
REQ-036 jump_in=2 jraddr_in=0x200 with branchSel_in=1 branchaddr_in=0x300 -> next PC=0x200.
REQ-037 PC=0x10, halt_in=1 -> next cycles iREN=0, PC=0x10; later branchSel_in=1 ignored; only nRST=0 restores PC=0.
REQ-038 Stall with ihit at PC=0x20: without macro PC stays 0x20; with STAGE_FETCH_IBUF_EN PC=0x24, buffer delivers npc_out=0x24 when stall drops.
REQ-039 PC=32'hFFFFFFFC, ihit=1 -> npc_out=0, next imemaddr=0.
